// File: rtl/sumador_serial.sv
// Bit-serial adder: Sum = A + B + Cin, one bit per clock LSB first, with N/Z/C/V flags.
// A single full-adder cell walks the operand shift registers; results commit only on the last bit.
module sumador_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             busy,
    output logic             done,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic             r_carry, r_sa, r_sb;
    logic [CW-1:0]    r_cnt;

    logic             w_last, w_accept, w_sbit, w_cout;
    logic [WIDTH-1:0] w_res_nxt;

    assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(WIDTH-1));
    assign w_accept  = start && (r_state != SHIFT);
    assign w_sbit    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cout    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_res_nxt = {w_sbit, r_res[WIDTH-1:1]};

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_cnt   <= '0;
            Sum     <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_res   <= '0;
            r_carry <= Cin;
            r_sa    <= A[WIDTH-1];
            r_sb    <= B[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_nxt;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            // Visible outputs change only here, so partial sums never leak out.
            if (w_last) begin
                Sum    <= w_res_nxt;
                flag_c <= w_cout;
                flag_n <= w_res_nxt[WIDTH-1];
                flag_z <= (w_res_nxt == '0);
                flag_v <= (r_sa == r_sb) && (w_res_nxt[WIDTH-1] != r_sa);
            end
        end
    end
endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial at WIDTH=4 and WIDTH=8 against an arithmetic reference.
module tb_sumador_serial;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       st4, c4, busy4, d4, n4, z4, cf4, v4;
    logic [3:0] a4, b4, s4;
    logic       st8, c8, busy8, d8, n8, z8, cf8, v8;
    logic [7:0] a8, b8, s8;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] last4, last8;

    always #5 clk = ~clk;

    sumador_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .A(a4), .B(b4), .Cin(c4),
        .Sum(s4), .busy(busy4), .done(d4),
        .flag_n(n4), .flag_z(z4), .flag_c(cf4), .flag_v(v4)
    );

    sumador_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .A(a8), .B(b8), .Cin(c8),
        .Sum(s8), .busy(busy8), .done(d8),
        .flag_n(n8), .flag_z(z8), .flag_c(cf8), .flag_v(v8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result word: {C,V,Z,N} at bits 11:8, sum in the low bits.
    function automatic logic [31:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [31:0] mask, full, sum;
        logic        c, n, z, v, sa, sb;
        mask = (32'd1 << w) - 32'd1;
        full = (a & mask) + (b & mask) + {31'd0, ci};
        sum  = full & mask;
        c    = full[w];
        n    = sum[w-1];
        z    = (sum == 32'd0);
        sa   = a[w-1];
        sb   = b[w-1];
        v    = (sa == sb) && (n != sa);
        return {20'd0, c, v, z, n, sum[7:0]};
    endfunction

    function automatic logic [31:0] obs4();
        return {20'd0, cf4, v4, z4, n4, 4'd0, s4};
    endfunction

    function automatic logic [31:0] obs8();
        return {20'd0, cf8, v8, z8, n8, s8};
    endfunction

    // One operation; operands are scrambled while busy to show they are ignored.
    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [31:0] exp;
        int cyc, nb;
        exp = ref_add(4, {28'd0, a}, {28'd0, b}, ci);
        a4 = a; b4 = b; c4 = ci; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0; cyc = 0; nb = 0;
        while (!d4 && cyc < 20) begin
            nb += int'(busy4);
            chk("hold4", obs4(), last4);
            a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("lat4", cyc, 4);
        chk("busy4", nb, 4);
        chk("res4", obs4(), exp);
        last4 = exp;
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        logic [31:0] exp;
        int cyc;
        exp = ref_add(8, {24'd0, a}, {24'd0, b}, ci);
        a8 = a; b8 = b; c8 = ci; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0; cyc = 0;
        while (!d8 && cyc < 30) begin
            chk("hold8", obs8(), last8);
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("lat8", cyc, 8);
        chk("res8", obs8(), exp);
        last8 = exp;
    endtask

    logic [3:0] qa [20];
    logic [3:0] qb [20];
    logic       qc [20];
    logic [31:0] e;

    initial begin
        rst_n = 1'b0; st4 = 1'b0; st8 = 1'b0;
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; a8 = '0; b8 = '0; c8 = 1'b0;
        last4 = '0; last8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_out4", {busy4, d4, obs4()}, 34'd0);
        chk("rst_out8", {busy8, d8, obs8()}, 34'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run4(4'd3, 4'd4, 1'b0);
        run4(4'd7, 4'd1, 1'b0);
        run4(4'd8, 4'd8, 1'b0);
        run4(4'd15, 4'd0, 1'b1);
        run4(4'd5, 4'd10, 1'b1);
        for (int i = 0; i < 8; i++)
            run4(4'($urandom), 4'($urandom), 1'($urandom));

        // Start held high: operands are taken every 5th edge only.
        for (int j = 0; j < 20; j++) begin
            qa[j] = 4'($urandom); qb[j] = 4'($urandom); qc[j] = 1'($urandom);
            a4 = qa[j]; b4 = qb[j]; c4 = qc[j]; st4 = 1'b1;
            @(negedge clk);
            if (j % 5 == 4) begin
                e = ref_add(4, {28'd0, qa[j-4]}, {28'd0, qb[j-4]}, qc[j-4]);
                chk("b2b_done", {31'd0, d4}, 32'd1);
                chk("b2b_res", obs4(), e);
                last4 = e;
            end else begin
                chk("b2b_nodone", {31'd0, d4}, 32'd0);
                chk("b2b_hold", obs4(), last4);
            end
        end
        st4 = 1'b0;
        @(negedge clk);

        // Abort with reset while the bit counter is at 2.
        a4 = 4'd9; b4 = 4'd9; c4 = 1'b1; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_out", {busy4, d4, obs4()}, 34'd0);
        last4 = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_nodone", {busy4, d4}, 2'b00);
        end
        run4(4'd6, 4'd9, 1'b0);
        run4(4'd11, 4'd12, 1'b1);

        run8(8'h7F, 8'h01, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h80, 8'h80, 1'b1);
        for (int i = 0; i < 4; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/sumador_serial.md
Name: sumador_serial

Overview:
Bit-serial N-bit adder computing A + B + Cin one bit per clock, LSB first.
- Produces a registered sum and N/Z/C/V flags.
- Is the add-direction counterpart to the team's full subtractor and uses the same flag definitions, so flag consumers treat both units identically.
- Sits in the lab ALU datapath behind a start/busy/done handshake, trading latency for a single 1-bit full-adder cell.

Parameters:
WIDTH, 4, operand/sum width in bits (>= 2)

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset (sampled on rising clk edge)
start  input  1  request; operands sampled on the edge where start=1 and the block is not busy
A  input  WIDTH  augend (unsigned or two's complement)
B  input  WIDTH  addend
Cin  input  1  carry-in
Sum  output  WIDTH  registered result A+B+Cin mod 2^WIDTH
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: Sum/flags just updated
flag_n  output  1  Negative: Sum[WIDTH-1]
flag_z  output  1  Zero: Sum == 0
flag_c  output  1  Carry out of bit WIDTH-1
flag_v  output  1  Signed overflow: A[WIDTH-1]==B[WIDTH-1] and Sum[WIDTH-1]!=A[WIDTH-1]

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; Sum, flags, busy and done all 0; internal shift registers, carry and bit counter cleared. Reset wins over any other input on the same edge.
- Reset mid-operation aborts the operation; no done pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 at an edge:
  - Latch A, B into shift registers.
  - Latch Cin into the carry register.
  - Latch A[WIDTH-1] and B[WIDTH-1] for the V flag.
  - Set counter=0 and go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each edge:
  - Full-add the LSBs plus the carry.
  - Shift the sum bit into the result shift register at the MSB end.
  - Shift the operand registers right and update the carry.
  - counter++.
  - When counter reaches WIDTH-1 on this edge (the last bit), go to DONE and commit the result shift register to Sum, the final carry to flag_c, and compute flag_n/z/v from the committed value.
- DONE: done=1 for exactly this cycle, then the next edge leaves DONE.
  - start=1 on that edge: accept the new operands and go to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- busy=1 exactly while state==SHIFT. start while busy is ignored, and operand changes while busy have no effect.
- Latency: operands sampled at edge 0; Sum/flags valid and done=1 in the cycle after edge WIDTH.
- Throughput: one result per WIDTH+1 cycles.
- Sum and flags hold their values from completion until the next completion or reset. They never show partial results.
- Arithmetic is mod 2^WIDTH; no saturation.
- flag_c is the true carry-out, not an inverted borrow.
- flag_v uses the latched operand sign bits, not the live inputs.
- Counter width is clog2(WIDTH), minimum 1.

Test Plan:
- WIDTH=4, reset then A=3, B=4, Cin=0, start pulse -> done exactly 4 edges later; Sum=7, N=0 Z=0 C=0 V=0; busy high for 4 cycles.
- A=7, B=1, Cin=0 -> Sum=8, N=1 Z=0 C=0 V=1. Then A=8, B=8, Cin=0 -> Sum=0, N=0 Z=1 C=1 V=1.
- A=15, B=0, Cin=1 -> Sum=0, Z=1, C=1, V=0. Also A=5, B=10, Cin=1 -> Sum=0, Z=1, C=1, V=0.
- Start held high continuously with changing operands -> only operands sampled in IDLE/DONE are used; back-to-back results every 5 cycles; mid-op operand changes are ignored; Sum stays stable between done pulses.
- rst_n=0 for one edge while counter=2 -> all outputs 0 next cycle, no done pulse; a new start then completes normally with the correct result.
- WIDTH=8: A=0x7F, B=0x01, Cin=0 -> done 8 edges after start; Sum=0x80, N=1, V=1, C=0.
